// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store access path.
package mem_pkg;

  // Access size; the encoding is the log2 of the byte count.
  typedef enum logic [1:0] {
    MEM_W1 = 2'd0,
    MEM_W2 = 2'd1,
    MEM_W4 = 2'd2,
    MEM_W8 = 2'd3
  } mem_width_t;

  // Access unit FSM encoding, kept as plain constants for older users.
  typedef logic [1:0] mem_state_t;
  localparam mem_state_t ST_IDLE = 2'd0;
  localparam mem_state_t ST_EXC  = 2'd1;
  localparam mem_state_t ST_ADDR = 2'd2;
  localparam mem_state_t ST_WAIT = 2'd3;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] width_bytes(input mem_width_t w);
    return 4'd1 << w;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the access unit: alignment check, strobes,
// write-data placement and read-data extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(LANES)
) (
  // request side
  input  mem_width_t          width,
  input  logic [2:0]          addr_lo,
  input  logic [DATA_W-1:0]   wdata,
  output logic                misalign,
  output logic [LANES-1:0]    strb,
  output logic [DATA_W-1:0]   wdata_lane,
  // response side, driven from the latched request
  input  mem_width_t          rd_width,
  input  logic [OFF_W-1:0]    rd_off,
  input  logic                rd_signed,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   rdata_ext
);

  // Ones over the low n bytes of a word; an oversize width covers every lane.
  function automatic logic [DATA_W-1:0] byte_mask(input mem_width_t w);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(width_bytes(w))) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Shift the addressed bytes down to bit 0, then sign- or zero-fill above them.
  function automatic logic [DATA_W-1:0] extract(input mem_width_t        w,
                                                input logic [OFF_W-1:0]  off,
                                                input logic              sgn,
                                                input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] m;
    logic              sb;
    x = d >> {off, 3'b000};
    m = byte_mask(w);
    case (w)
      MEM_W1:  sb = x[7];
      MEM_W2:  sb = x[15];
      MEM_W4:  sb = x[31];
      default: sb = x[DATA_W-1];
    endcase
    return (x & m) | ((sgn && sb) ? ~m : '0);
  endfunction

  logic [OFF_W-1:0] off;
  logic [LANES-1:0] strb_base;

  assign off = addr_lo[OFF_W-1:0];

  // Alignment check; an 8-byte access on a narrower bus can never be legal.
  always_comb begin
    misalign = 1'b0;
    case (width)
      MEM_W1:  misalign = 1'b0;
      MEM_W2:  misalign = addr_lo[0];
      MEM_W4:  misalign = |addr_lo[1:0];
      default: misalign = (LANES < 8) ? 1'b1 : |addr_lo;
    endcase
  end

  // Lane enables for the low n bytes, then moved up to the addressed lane.
  always_comb begin
    strb_base = '0;
    for (int i = 0; i < LANES; i++) begin
      strb_base[i] = (i < int'(width_bytes(width)));
    end
    strb       = strb_base << off;
    wdata_lane = (wdata & byte_mask(width)) << {off, 3'b000};
  end

  assign rdata_ext = extract(rd_width, rd_off, rd_signed, rdata);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit between the MEM stage and the data bus.
// One access in flight; all bus and response outputs are registered.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  // pipeline request
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_width,
  input  logic                   req_signed,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  // pipeline response
  output logic                   resp_valid,
  output logic                   resp_exc,
  output logic [DATA_W-1:0]      resp_rdata,
  // data bus
  output logic                   bus_valid,
  input  logic                   bus_ready,
  output logic                   bus_write,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [DATA_W/8-1:0]    bus_strb,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic                   bus_rvalid,
  input  logic [DATA_W-1:0]      bus_rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  mem_state_t        state;
  mem_width_t        width_p0;
  logic [OFF_W-1:0]  off_p0;
  logic              signed_p0;
  logic              write_p0;

  logic              misalign;
  logic [LANES-1:0]  strb;
  logic [DATA_W-1:0] wdata_lane;
  logic [DATA_W-1:0] rdata_ext;

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .width      (mem_width_t'(req_width)),
    .addr_lo    (req_addr[2:0]),
    .wdata      (req_wdata),
    .misalign   (misalign),
    .strb       (strb),
    .wdata_lane (wdata_lane),
    .rd_width   (width_p0),
    .rd_off     (off_p0),
    .rd_signed  (signed_p0),
    .rdata      (bus_rdata),
    .rdata_ext  (rdata_ext)
  );

  // FSM, handshakes and response pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      bus_valid  <= 1'b0;
      resp_valid <= 1'b0;
      resp_exc   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_exc   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (misalign) begin
              state      <= ST_EXC;
              resp_valid <= 1'b1;
              resp_exc   <= 1'b1;
            end else begin
              state     <= ST_ADDR;
              bus_valid <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_EXC: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        ST_ADDR: begin
          if (bus_ready) begin
            state     <= ST_WAIT;
            bus_valid <= 1'b0;
          end
        end
        default: begin
          // Stores complete with a zero result; loads return the extended lane.
          if (bus_rvalid) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_rdata <= write_p0 ? '0 : rdata_ext;
          end
        end
      endcase
    end
  end

  // Latch request fields and bus payload on acceptance; they hold until the next accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      width_p0  <= MEM_W1;
      off_p0    <= '0;
      signed_p0 <= 1'b0;
      write_p0  <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_strb  <= '0;
      bus_wdata <= '0;
    end else if (state == ST_IDLE && req_valid) begin
      width_p0  <= mem_width_t'(req_width);
      off_p0    <= req_addr[OFF_W-1:0];
      signed_p0 <= req_signed;
      write_p0  <= req_write;
      bus_write <= req_write;
      bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      bus_strb  <= strb;
      bus_wdata <= req_write ? wdata_lane : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one 32-bit and one 64-bit instance sharing
// stimulus, directed cases followed by randomized accesses against a model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  bit          sel;            // 0 = 32-bit instance, 1 = 64-bit instance
  logic        rv32, rv64;
  logic        req_write;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        bus_ready, bus_rvalid;
  logic [63:0] bus_rdata;

  logic        r32_ready, p32_valid, p32_exc, b32_valid, b32_write;
  logic [31:0] p32_rdata, b32_addr, b32_wdata;
  logic [3:0]  b32_strb;
  logic        r64_ready, p64_valid, p64_exc, b64_valid, b64_write;
  logic [63:0] p64_rdata, b64_wdata;
  logic [31:0] b64_addr;
  logic [7:0]  b64_strb;

  logic        o_req_ready, o_resp_valid, o_resp_exc, o_bus_valid, o_bus_write;
  logic [63:0] o_resp_rdata, o_bus_wdata;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_strb;

  int passed = 0;
  int total  = 0;

  logic [31:0] last_addr;
  logic [7:0]  last_strb;
  logic [63:0] last_wdata, last_rdata;
  logic        last_exc;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .resetn(resetn),
    .req_valid(rv32), .req_ready(r32_ready), .req_write(req_write),
    .req_width(req_width), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .resp_valid(p32_valid), .resp_exc(p32_exc), .resp_rdata(p32_rdata),
    .bus_valid(b32_valid), .bus_ready(bus_ready), .bus_write(b32_write),
    .bus_addr(b32_addr), .bus_strb(b32_strb), .bus_wdata(b32_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata[31:0])
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .resetn(resetn),
    .req_valid(rv64), .req_ready(r64_ready), .req_write(req_write),
    .req_width(req_width), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(p64_valid), .resp_exc(p64_exc), .resp_rdata(p64_rdata),
    .bus_valid(b64_valid), .bus_ready(bus_ready), .bus_write(b64_write),
    .bus_addr(b64_addr), .bus_strb(b64_strb), .bus_wdata(b64_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  assign o_req_ready  = sel ? r64_ready : r32_ready;
  assign o_resp_valid = sel ? p64_valid : p32_valid;
  assign o_resp_exc   = sel ? p64_exc   : p32_exc;
  assign o_resp_rdata = sel ? p64_rdata : {32'b0, p32_rdata};
  assign o_bus_valid  = sel ? b64_valid : b32_valid;
  assign o_bus_write  = sel ? b64_write : b32_write;
  assign o_bus_addr   = sel ? b64_addr  : b32_addr;
  assign o_bus_strb   = sel ? b64_strb  : {4'b0, b32_strb};
  assign o_bus_wdata  = sel ? b64_wdata : {32'b0, b32_wdata};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // The bench must never present a response during the request handshake.
  always @(posedge clk) begin
    if (resetn === 1'b1 && bus_ready && bus_rvalid && (b32_valid || b64_valid)) begin
      total++;
      $error("FAIL proto_rvalid_in_handshake observed=1 expected=0");
    end
  end

  // Reference: what an access should produce, from the byte-lane rules.
  task automatic model(input int dw, input bit wr, input logic [1:0] w, input bit sg,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       output bit exc, output logic [31:0] baddr, output logic [7:0] strb,
                       output logic [63:0] bwd, output logic [63:0] rdo);
    int lanes = dw / 8;
    int n     = 1 << w;
    int off   = int'(a % lanes);
    logic [127:0] m, t, x, dmask;
    dmask = (dw == 64) ? {64'b0, {64{1'b1}}} : {96'b0, {32{1'b1}}};
    m     = (128'd1 << (8 * n)) - 128'd1;
    exc   = (n > lanes) || ((a % n) != 0);
    baddr = a - off;
    strb  = 8'(((1 << n) - 1) << off);
    t     = ({64'b0, wd} & m) << (8 * off);
    bwd   = wr ? 64'(t & dmask) : 64'b0;
    x     = (({64'b0, rd} & dmask) >> (8 * off)) & m;
    if (sg && x[8*n-1]) x = x | ~m;
    rdo   = (wr || exc) ? 64'b0 : 64'(x & dmask);
  endtask

  // One complete access on the selected instance with chosen bus stalls.
  task automatic do_access(input bit wr, input logic [1:0] w, input bit sg,
                           input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                           input int rdy_dly, input int rv_dly);
    bit          e_exc;
    logic [31:0] e_addr;
    logic [7:0]  e_strb;
    logic [63:0] e_wd, e_rd;
    model(sel ? 64 : 32, wr, w, sg, a, wd, rd, e_exc, e_addr, e_strb, e_wd, e_rd);
    chk("idle_ready", o_req_ready, 1);
    req_write = wr; req_width = w; req_signed = sg; req_addr = a; req_wdata = wd;
    if (sel) rv64 = 1'b1; else rv32 = 1'b1;
    @(posedge clk); #1;
    rv32 = 1'b0; rv64 = 1'b0;
    req_wdata = {$urandom, $urandom};
    if (e_exc) begin
      chk("exc_valid", o_resp_valid, 1);
      chk("exc_flag", o_resp_exc, 1);
      chk("exc_rdata", o_resp_rdata, 0);
      chk("exc_busv", o_bus_valid, 0);
      last_exc = o_resp_exc;
      @(posedge clk); #1;
      chk("exc_pulse_end", o_resp_valid, 0);
      chk("exc_busv2", o_bus_valid, 0);
      chk("exc_ready", o_req_ready, 1);
      return;
    end
    chk("acc_noresp", o_resp_valid, 0);
    for (int k = 0; k <= rdy_dly; k++) begin
      bus_ready = (k == rdy_dly);
      chk("bus_valid", o_bus_valid, 1);
      chk("bus_write", o_bus_write, wr);
      chk("bus_addr", o_bus_addr, e_addr);
      chk("bus_strb", o_bus_strb, e_strb);
      chk("bus_wdata", o_bus_wdata, e_wd);
      chk("busy_ready", o_req_ready, 0);
      last_addr = o_bus_addr; last_strb = o_bus_strb; last_wdata = o_bus_wdata;
      @(posedge clk); #1;
    end
    bus_ready = 1'b0;
    chk("bus_valid_drop", o_bus_valid, 0);
    for (int k = 0; k < rv_dly; k++) begin
      chk("wait_noresp", o_resp_valid, 0);
      @(posedge clk); #1;
    end
    bus_rvalid = 1'b1; bus_rdata = rd;
    @(posedge clk); #1;
    bus_rvalid = 1'b0; bus_rdata = {$urandom, $urandom};
    chk("resp_valid", o_resp_valid, 1);
    chk("resp_exc", o_resp_exc, 0);
    chk("resp_rdata", o_resp_rdata, e_rd);
    last_rdata = o_resp_rdata; last_exc = o_resp_exc;
    @(posedge clk); #1;
    chk("resp_pulse_end", o_resp_valid, 0);
    chk("done_ready", o_req_ready, 1);
  endtask

  initial begin
    logic [63:0] rd;
    resetn = 1'b0; sel = 1'b0; rv32 = 1'b0; rv64 = 1'b0;
    req_write = 1'b0; req_width = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    // Reset state and first-clock ready.
    @(posedge clk); #1;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_busv", o_bus_valid, 0);
    chk("rst_respv", o_resp_valid, 0);
    chk("rst_strb", o_bus_strb, 0);
    #2 resetn = 1'b1;
    #1 chk("rst_release_ready", o_req_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_rst", o_req_ready, 1);
    sel = 1'b1;
    chk("ready_after_rst64", o_req_ready, 1);
    sel = 1'b0;

    // 32-bit directed cases.
    do_access(1, 2'd0, 0, 32'h1003, 64'h1234_56A5, 64'h5555_AAAA, 0, 0);
    chk("sb_addr", last_addr, 32'h1000);
    chk("sb_strb", last_strb, 8'h08);
    chk("sb_wdata", last_wdata, 64'hA500_0000);
    chk("sb_rdata", last_rdata, 0);
    do_access(0, 2'd1, 1, 32'h2002, 64'h0, 64'h8001_1234, 0, 0);
    chk("lh_rdata", last_rdata, 64'hFFFF_8001);
    do_access(0, 2'd1, 0, 32'h2002, 64'h0, 64'h8001_1234, 0, 1);
    chk("lhu_rdata", last_rdata, 64'h0000_8001);
    do_access(0, 2'd0, 1, 32'h2001, 64'h0, 64'h8001_1234, 1, 0);
    chk("lb_rdata", last_rdata, 64'h0000_0012);
    last_exc = 1'b0;
    do_access(0, 2'd2, 0, 32'h3002, 64'h0, 64'h0, 0, 0);
    chk("lw_mis_exc", last_exc, 1);
    last_exc = 1'b0;
    do_access(0, 2'd3, 0, 32'h3000, 64'h0, 64'h0, 0, 0);
    chk("w8_on32_exc", last_exc, 1);
    do_access(0, 2'd2, 1, 32'h3004, 64'h0, 64'hCAFE_F00D, 5, 2);
    chk("lw_stall_rdata", last_rdata, 64'hCAFE_F00D);

    // Reset during WAIT of a store, then stray rvalid in IDLE.
    req_write = 1'b1; req_width = 2'd1; req_signed = 1'b0; req_addr = 32'h5002;
    req_wdata = 64'h0000_BEEF; rv32 = 1'b1;
    @(posedge clk); #1;
    rv32 = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    chk("pre_rst_strb", o_bus_strb, 8'h0C);
    resetn = 1'b0;
    #1;
    chk("midrst_strb", o_bus_strb, 0);
    chk("midrst_wdata", o_bus_wdata, 0);
    chk("midrst_addr", o_bus_addr, 0);
    chk("midrst_write", o_bus_write, 0);
    chk("midrst_ready", o_req_ready, 0);
    chk("midrst_respv", o_resp_valid, 0);
    @(posedge clk); #3;
    resetn = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stray_rvalid", o_resp_valid, 0);
    end
    bus_rvalid = 1'b0;
    do_access(0, 2'd2, 0, 32'h6000, 64'h0, 64'h1357_9BDF, 0, 0);
    chk("post_rst_rdata", last_rdata, 64'h1357_9BDF);

    // 64-bit directed cases.
    sel = 1'b1;
    rd = {$urandom, $urandom};
    do_access(0, 2'd3, 1, 32'h4008, 64'h0, rd, 0, 0);
    chk("ld_strb", last_strb, 8'hFF);
    chk("ld_rdata", last_rdata, rd);
    do_access(1, 2'd2, 0, 32'h4004, 64'h1111_2222_DEAD_BEEF, 64'h0, 0, 0);
    chk("sw64_strb", last_strb, 8'hF0);
    chk("sw64_wdata", last_wdata, 64'hDEAD_BEEF_0000_0000);

    // Randomized accesses on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 40; i++) begin
        logic [1:0]  w;
        logic [31:0] a;
        w = 2'($urandom_range(0, 3));
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << w) - 32'd1);
        do_access(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
